vga_timing_800x600: RTL
=======================

VGA_TIMING_800X600 -- requirements
Module: vga_timing_800x600

Interface
REQ-001 SHALL have parameter H_VIS, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 56 / 120 / 64, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VIS, default 600, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 37 / 6 / 23, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 1 / 1, active level of sync pulses.
REQ-006 SHALL have port clkin  input  1  50 MHz pixel clock, one clock domain, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port locked  input  1  PLL lock; low is treated as a held reset.
REQ-009 SHALL have port fb_rd  output  1  framebuffer read strobe.
REQ-010 SHALL have port fb_addr  output  19  framebuffer word address, RGB444 pixel.
REQ-011 SHALL have port fb_data  input  12  pixel {R,G,B} returned exactly 1 clock after fb_rd.
REQ-012 SHALL have ports vga_r / vga_g / vga_b  output  4 each  colour outputs.
REQ-013 SHALL have ports vga_hs / vga_vs  output  1 each  sync outputs.
REQ-014 SHALL have port frame_start  output  1  one-clock pulse at the first visible pixel of each frame.

Function
REQ-015 SHALL hold h_cnt 0..H_TOT-1 (H_TOT=1040) incrementing every clock and wrapping to 0.
REQ-016 SHALL hold v_cnt 0..V_TOT-1 (V_TOT=666), advancing only when h_cnt wraps, and wrapping to 0 when both are at their maximum in the same clock.
REQ-017 SHALL treat stage 0 as active when h_cnt<H_VIS and v_cnt<V_VIS.
REQ-018 SHALL treat stage 0 as hsync when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, and vsync by the analogous v_cnt range.
REQ-019 SHALL register stage 1 from stage 0: fb_rd=active; fb_addr=running address; delayed hs, vs and active.
REQ-020 SHALL generate the running address without a multiplier: clear to 0 at (h=0,v=0), increment after each active pixel, giving v*800+h; maximum 479999.
REQ-021 SHALL register stage 2 from stage 1 plus fb_data: RGB=fb_data when delayed active, else 0; vga_hs/vga_vs = delayed sync XNOR POL.
REQ-022 SHALL therefore delay vga_r/g/b, vga_hs and vga_vs by exactly 2 clocks from the counter state, mutually aligned.
REQ-023 SHALL assert frame_start aligned with the stage-2 colour of pixel (0,0).
REQ-024 SHALL hold fb_addr stable while fb_rd is low; fb_addr SHALL not be sampled by memory when fb_rd is 0.
REQ-025 SHALL behave as reset on any clock where locked=0; on locked rising, counting SHALL resume from (0,0) on the next clock.

Reset
REQ-026 SHALL, while rst=1 or locked=0, set h_cnt=0, v_cnt=0, address=0, fb_rd=0, fb_addr=0, RGB=0, frame_start=0, and vga_hs/vga_vs inactive (=~POL); all pipeline valid bits 0.
REQ-027 SHALL handle reset mid-frame by aborting the frame; no partial sync pulse persists past the reset clock plus 2.

Structure
REQ-028 SHALL place the timing defaults (H/V widths, totals, polarities, FB_AW=19) in shared package vga_pkg, for reuse by other video modes.
REQ-029 SHALL use one sub-module, vga_sync_counter (h/v counters plus active/sync decode); the pipeline and address logic SHALL be in the top.

Verification
REQ-030 SHALL verify: release rst with locked=1 -> first fb_rd=1 at clock 1 with fb_addr=0; frame_start at clock 2.
REQ-031 SHALL verify: count one line -> vga_hs active for 120 clocks, starting 856+2 clocks after h_cnt=0; line period 1040.
REQ-032 SHALL verify: full frame -> 480000 fb_rd pulses, last fb_addr=479999, vga_vs active for 6240 clocks, frame period 692640 clocks.
REQ-033 SHALL verify: fb_data = {h[3:0],v[3:0],4'hA} model -> every visible vga_r/g/b matches the model 2 clocks later, and is 0 in blanking.
REQ-034 SHALL verify: drop locked at h=400,v=300 for 5 clocks -> outputs reach reset values within 2 clocks, restart at (0,0), fb_addr=0.
REQ-035 SHALL verify: HS_POL=0, VS_POL=0 -> sync outputs idle high and pulse low for the same durations.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared video timing defaults and pipeline types for VGA timing generators.
// The 800x600@72 Hz mode (50 MHz pixel clock) is the default set.
package vga_pkg;

  localparam int H_VIS_D  = 800;
  localparam int H_FP_D   = 56;
  localparam int H_SYNC_D = 120;
  localparam int H_BP_D   = 64;
  localparam int H_TOT_D  = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_VIS_D  = 600;
  localparam int V_FP_D   = 37;
  localparam int V_SYNC_D = 6;
  localparam int V_BP_D   = 23;
  localparam int V_TOT_D  = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam bit HS_POL_D = 1'b1;
  localparam bit VS_POL_D = 1'b1;

  localparam int FB_AW = 19;
  localparam int FB_DW = 12;
  localparam int H_CW  = 11;
  localparam int V_CW  = 10;

  // Per-pixel control decoded from the counters, carried down the pipeline.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic first;
  } vga_ctl_t;

endpackage

// File: rtl/vga_timing_800x600_if.sv
// Framebuffer read port: the timing generator issues reads, memory returns
// the pixel one clock later.
interface vga_timing_800x600_if;
  import vga_pkg::*;

  logic             fb_rd;
  logic [FB_AW-1:0] fb_addr;
  logic [FB_DW-1:0] fb_data;

  modport master (output fb_rd, output fb_addr, input fb_data);
  modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with stage-0 active and sync decode.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_VIS  = V_VIS_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D
) (
  input  logic     clk,
  input  logic     i_clr,
  output vga_ctl_t o_ctl
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [H_CW-1:0] H_LAST = H_CW'(H_TOT - 1);
  localparam logic [H_CW-1:0] H_ACT  = H_CW'(H_VIS);
  localparam logic [H_CW-1:0] H_SS   = H_CW'(H_VIS + H_FP);
  localparam logic [H_CW-1:0] H_SE   = H_CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST = V_CW'(V_TOT - 1);
  localparam logic [V_CW-1:0] V_ACT  = V_CW'(V_VIS);
  localparam logic [V_CW-1:0] V_SS   = V_CW'(V_VIS + V_FP);
  localparam logic [V_CW-1:0] V_SE   = V_CW'(V_VIS + V_FP + V_SYNC);

  logic [H_CW-1:0] r_h_cnt;
  logic [V_CW-1:0] r_v_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + V_CW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_CW'(1);
    end
  end

  always_comb begin
    o_ctl        = '0;
    o_ctl.active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    o_ctl.hsync  = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
    o_ctl.vsync  = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
    o_ctl.first  = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

endmodule

// File: rtl/vga_timing_800x600.sv
// VGA timing generator: counters -> framebuffer read (stage 1) -> colour and
// sync outputs (stage 2). Outputs trail the counter state by two clocks.
module vga_timing_800x600
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_VIS  = V_VIS_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter bit HS_POL = HS_POL_D,
  parameter bit VS_POL = VS_POL_D
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       locked,
  vga_timing_800x600_if.master fb,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start
);

  logic             w_clr;
  vga_ctl_t         w_ctl0;
  logic [FB_AW-1:0] w_addr;

  logic [FB_AW-1:0] r_addr;
  vga_ctl_t         r_ctl1;
  logic             r_fb_rd;
  logic [FB_AW-1:0] r_fb_addr;
  logic [FB_DW-1:0] r_rgb;
  logic             r_hs2;
  logic             r_vs2;
  logic             r_fs2;

  // An unlocked PLL gives an untrustworthy clock, so it aborts the frame.
  assign w_clr = rst | ~locked;

  vga_sync_counter #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_cnt (
    .clk   (clkin),
    .i_clr (w_clr),
    .o_ctl (w_ctl0)
  );

  // Running address replaces v*H_VIS+h; restarting at (0,0) keeps it self-healing.
  assign w_addr = w_ctl0.first ? '0 : r_addr;

  always_ff @(posedge clkin) begin
    if (w_clr) begin
      r_addr    <= '0;
      r_ctl1    <= '0;
      r_fb_rd   <= 1'b0;
      r_fb_addr <= '0;
    end else begin
      r_ctl1  <= w_ctl0;
      r_fb_rd <= w_ctl0.active;
      if (w_ctl0.active) begin
        r_fb_addr <= w_addr;
        r_addr    <= w_addr + FB_AW'(1);
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (w_clr) begin
      r_rgb <= '0;
      r_hs2 <= ~HS_POL;
      r_vs2 <= ~VS_POL;
      r_fs2 <= 1'b0;
    end else begin
      r_rgb <= r_ctl1.active ? fb.fb_data : '0;
      r_hs2 <= ~(r_ctl1.hsync ^ HS_POL);
      r_vs2 <= ~(r_ctl1.vsync ^ VS_POL);
      r_fs2 <= r_ctl1.first;
    end
  end

  assign fb.fb_rd     = r_fb_rd;
  assign fb.fb_addr   = r_fb_addr;
  assign vga_r        = r_rgb[11:8];
  assign vga_g        = r_rgb[7:4];
  assign vga_b        = r_rgb[3:0];
  assign vga_hs       = r_hs2;
  assign vga_vs       = r_vs2;
  assign frame_start  = r_fs2;

endmodule
